port_uart: RTL

- Serial UART peripheral on the LCR580 CPU port bus, directly downstream of the CPU's OUT/IN cycles.
- Consumes port_we/port_rd, the low address byte and the CPU data output.
- Returns read data on the CPU's port_in input.
- Drives and receives an 8N1 serial line with a TX FIFO and a single-byte RX holding register.

---
 rtl/port_uart_pkg.sv | 22 ++
 rtl/port_uart_fifo.sv | 48 ++++
 rtl/port_uart.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/port_uart_pkg.sv
// Shared definitions for the port_uart peripheral: register offsets,
// status bit positions and the FSM state encoding used by TX and RX.
package port_uart_pkg;

  localparam logic [7:0] OFS_DATA = 8'd0;
  localparam logic [7:0] OFS_STAT = 8'd1;
  localparam logic [7:0] OFS_CTRL = 8'd2;

  localparam int ST_RXRDY  = 0;
  localparam int ST_TXNF   = 1;
  localparam int ST_TXIDLE = 2;
  localparam int ST_OE     = 3;
  localparam int ST_FE     = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/port_uart_fifo.sv
// Synchronous FIFO for the UART transmit path; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module port_uart_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                 (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/port_uart.sv
// 8N1 UART on the CPU port bus: data at BASE, status at BASE+1.
// Defining PORT_UART_LOOPBACK_EN adds a loopback control register at BASE+2.
//   state | meaning (TX and RX)
//   IDLE  | line idle, waiting for FIFO data / start edge
//   START | start bit
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit
module port_uart
  import port_uart_pkg::*;
#(
  parameter logic [7:0] BASE          = 8'h10,
  parameter int         CLK_DIV       = 217,
  parameter int         TX_DEPTH_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [7:0] port_addr,
  input  logic [7:0] port_wdata,
  input  logic       port_we,
  input  logic       port_rd,
  output logic [7:0] port_rdata,
  output logic       irq,
  output logic       txd,
  input  logic       rxd
);

  localparam int               CNT_W     = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] DIV_M1    = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [7:0]       ADDR_DATA = 8'(BASE + OFS_DATA);
  localparam logic [7:0]       ADDR_STAT = 8'(BASE + OFS_STAT);

  logic wr_data;
  logic rd_data;
  logic rd_stat;

  assign wr_data = ce & port_we & (port_addr == ADDR_DATA);
  assign rd_data = ce & port_rd & (port_addr == ADDR_DATA);
  assign rd_stat = ce & port_rd & (port_addr == ADDR_STAT);

  // ---------------- transmit ----------------
  logic [7:0]       fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             tx_pop;
  uart_state_e      tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             txd_q;
  logic             tx_idle;

  port_uart_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (wr_data),
    .pop   (tx_pop),
    .wdata (port_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Popping at the end of STOP chains frames with no idle gap.
  assign tx_pop  = ~fifo_empty &
                   ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == '0));
  assign tx_idle = fifo_empty & (tx_state == S_IDLE);
  assign txd     = txd_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_state <= S_START;
            tx_cnt   <= DIV_M1;
            tx_shift <= fifo_rdata;
            txd_q    <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt == '0) begin
            tx_state <= S_DATA;
            tx_cnt   <= DIV_M1;
            tx_bit   <= '0;
            txd_q    <= tx_shift[0];
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= DIV_M1;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              txd_q    <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd_q    <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == '0) begin
            if (tx_pop) begin
              tx_state <= S_START;
              tx_cnt   <= DIV_M1;
              tx_shift <= fifo_rdata;
              txd_q    <= 1'b0;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive ----------------
  logic             rx_in;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_prev;
  logic             rx_fall;
  uart_state_e      rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_store;
  logic [7:0]       rx_hold;
  logic             rx_ready;
  logic             oe;
  logic             fe;

`ifdef PORT_UART_LOOPBACK_EN
  localparam logic [7:0] ADDR_CTRL = 8'(BASE + OFS_CTRL);
  logic loopback;

  always_ff @(posedge clock) begin
    if (reset) loopback <= 1'b0;
    else if (ce & port_we & (port_addr == ADDR_CTRL)) loopback <= port_wdata[0];
  end

  assign rx_in = loopback ? txd_q : rxd;
`else
  assign rx_in = rxd;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall  = rx_prev & ~rx_s2;
  assign rx_store = (rx_state == S_STOP) && (rx_cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_state <= S_START;
            rx_cnt   <= HALF_M1;
          end
        end
        S_START: begin
          if (rx_cnt == '0) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
              rx_cnt   <= DIV_M1;
              rx_bit   <= '0;
            end
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == '0) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= DIV_M1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt == '0) rx_state <= S_IDLE;
          else              rx_cnt   <= rx_cnt - 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // A store wins over a same-cycle data read: the fresh byte stays pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_hold  <= '0;
      rx_ready <= 1'b0;
      oe       <= 1'b0;
      fe       <= 1'b0;
    end else begin
      if (rd_stat) begin
        oe <= 1'b0;
        fe <= 1'b0;
      end
      if (rx_store) begin
        rx_hold  <= rx_shift;
        rx_ready <= 1'b1;
        if (rx_ready & ~rd_data) oe <= 1'b1;
        if (~rx_s2)              fe <= 1'b1;
      end else if (rd_data) begin
        rx_ready <= 1'b0;
      end
    end
  end

  assign irq = rx_ready;

  // ---------------- read mux ----------------
  logic [7:0] status;

  always_comb begin
    status            = '0;
    status[ST_RXRDY]  = rx_ready;
    status[ST_TXNF]   = ~fifo_full;
    status[ST_TXIDLE] = tx_idle;
    status[ST_OE]     = oe;
    status[ST_FE]     = fe;
  end

  always_comb begin
    port_rdata = 8'hFF;
    if (port_addr == ADDR_DATA)      port_rdata = rx_hold;
    else if (port_addr == ADDR_STAT) port_rdata = status;
`ifdef PORT_UART_LOOPBACK_EN
    else if (port_addr == ADDR_CTRL) port_rdata = {7'b0, loopback};
`endif
  end

endmodule
